// File: rtl/cam_byte_packer.sv
// Packs a synchronised 8-bit camera stream into 24-bit words, buffers them in a
// FIFO and hands them to a PIO one at a time with an active-low ready bit.
module cam_byte_packer #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          capture_en,
  input  logic                          cam_pclk,
  input  logic                          cam_vsync,
  input  logic                          cam_href,
  input  logic [7:0]                    cam_data,
  input  logic                          ack_toggle,
  output logic [31:0]                   image_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;
  typedef struct packed {
    logic        sof;
    logic [23:0] payload;
  } word_t;

  // One shared chain keeps pclk, syncs and data mutually aligned.
  logic [SYNC_STAGES-1:0][10:0] sync_q;
  logic                         pclk_prev_q;
  logic                         s_pclk, s_vsync, s_href;
  logic [7:0]                   s_data;
  logic                         pclk_rise, vs_rise, href_fall;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [23:0] pack_q;
  logic        sof_pend_q, vs_prev_q, href_prev_q;
  logic        push_q;
  word_t       push_word_q;

  word_t       mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fifo_cnt_q;
  logic          ovf_q, ready_n_q, load_pend_q, ack_q;
  word_t         out_q;
  logic          full, pop, wr_ok;

  assign {s_pclk, s_vsync, s_href, s_data} = sync_q[SYNC_STAGES-1];
  assign pclk_rise = s_pclk & ~pclk_prev_q;
  assign vs_rise   = s_vsync & ~vs_prev_q;
  assign href_fall = ~s_href & href_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      pclk_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {cam_pclk, cam_vsync, cam_href, cam_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      pclk_prev_q <= s_pclk;
    end
  end

  // Capture FSM and byte packer; completed words leave through push_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      pack_q      <= '0;
      sof_pend_q  <= 1'b0;
      vs_prev_q   <= 1'b0;
      href_prev_q <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (pclk_rise) begin
        vs_prev_q   <= s_vsync;
        href_prev_q <= s_href;
      end
      if (!capture_en) begin
        state_q    <= IDLE;
        cnt_q      <= 2'd0;
        pack_q     <= '0;
        sof_pend_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: state_q <= WAIT_VS;
          WAIT_VS: begin
            if (pclk_rise && vs_prev_q && !s_vsync) begin
              state_q    <= ACTIVE;
              sof_pend_q <= 1'b1;
              cnt_q      <= 2'd0;
              pack_q     <= '0;
            end
          end
          ACTIVE: begin
            if (pclk_rise) begin
              if (vs_rise || href_fall) begin
                // Line or frame end: flush any partial word, zero-padded.
                if (cnt_q != 2'd0) begin
                  push_q      <= 1'b1;
                  push_word_q <= '{sof: sof_pend_q, payload: pack_q};
                  sof_pend_q  <= 1'b0;
                end
                cnt_q  <= 2'd0;
                pack_q <= '0;
                if (vs_rise) state_q <= WAIT_VS;
              end else if (s_href) begin
                if (cnt_q == 2'd2) begin
                  push_q      <= 1'b1;
                  push_word_q <= '{sof: sof_pend_q, payload: {pack_q[23:8], s_data}};
                  sof_pend_q  <= 1'b0;
                  cnt_q       <= 2'd0;
                  pack_q      <= '0;
                end else begin
                  if (cnt_q == 2'd0) pack_q[23:16] <= s_data;
                  else               pack_q[15:8]  <= s_data;
                  cnt_q <= cnt_q + 2'd1;
                end
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign full  = (fifo_cnt_q == FULL_CNT);
  assign pop   = capture_en && ready_n_q && !load_pend_q && (fifo_cnt_q != '0);
  assign wr_ok = capture_en && push_q && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= push_word_q;
  end

  // Presentation: load the word with ready_n high, drop ready_n a cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      ready_n_q   <= 1'b1;
      load_pend_q <= 1'b0;
      out_q       <= '0;
      ack_q       <= ack_toggle;
    end else begin
      ack_q <= ack_toggle;
      if (!capture_en) begin
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        fifo_cnt_q  <= '0;
        ovf_q       <= 1'b0;
        ready_n_q   <= 1'b1;
        load_pend_q <= 1'b0;
        out_q.sof   <= 1'b0;
      end else begin
        if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (push_q && full && !pop) ovf_q <= 1'b1;
        if (pop) begin
          rd_ptr_q    <= rd_ptr_q + 1'b1;
          out_q       <= mem_q[rd_ptr_q];
          load_pend_q <= 1'b1;
        end
        if (wr_ok && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
        else if (!wr_ok && pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;
        if (load_pend_q) begin
          ready_n_q   <= 1'b0;
          load_pend_q <= 1'b0;
        end else if (ack_toggle != ack_q) begin
          ready_n_q <= 1'b1;
        end
      end
    end
  end

  assign image_data = {ready_n_q, out_q.sof, ovf_q, 5'b0, out_q.payload};
  assign fifo_level = fifo_cnt_q;

endmodule

// File: tb/tb_cam_byte_packer.sv
// Scoreboard bench: expected words are queued by the stimulus thread and
// compared by a monitor at every ready_n falling edge.
module tb_cam_byte_packer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        capture_en = 1'b0;
  logic        cam_pclk = 1'b0, cam_vsync = 1'b0, cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        ack_toggle = 1'b0;
  logic [31:0] image_data;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic        auto_ack = 1'b0;

  cam_byte_packer #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .capture_en(capture_en),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .ack_toggle(ack_toggle),
    .image_data(image_data), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cam_cycle(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge clk);
    cam_vsync = vs; cam_href = hr; cam_data = d; cam_pclk = 1'b0;
    repeat (4) @(negedge clk);
    cam_pclk = 1'b1;
    repeat (4) @(negedge clk);
    cam_pclk = 1'b0;
  endtask

  task automatic frame_start();
    cam_cycle(1'b1, 1'b0, 8'h00);
    cam_cycle(1'b1, 1'b0, 8'h00);
    cam_cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_cycle(1'b0, 1'b1, b);
  endtask

  task automatic end_line();
    cam_cycle(1'b0, 1'b0, 8'h00);
  endtask

  // Third byte with an ack landing on the push cycle and a second ack one cycle later.
  task automatic send_byte_ack(input logic [7:0] b);
    @(negedge clk);
    cam_vsync = 1'b0; cam_href = 1'b1; cam_data = b; cam_pclk = 1'b0;
    repeat (4) @(negedge clk);
    cam_pclk = 1'b1;
    repeat (3) @(negedge clk);
    ack_toggle = ~ack_toggle;
    @(negedge clk);
    ack_toggle = ~ack_toggle;
    cam_pclk = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL %s: %0d words never presented, expected 0 pending", name, exp_q.size());
      exp_q.delete();
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic monitor_loop();
    logic        prev_rn = 1'b1;
    logic [31:0] prev_d = 32'h8000_0000;
    int          hi = 100;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_rn = 1'b1; hi = 100;
      end else begin
        if (prev_rn && !image_data[31]) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_word: got %h expected no presentation", image_data);
          end else begin
            chk("word", image_data, exp_q.pop_front());
          end
          chk("stable_before_fall", {7'b0, prev_d[30], prev_d[23:0]},
              {7'b0, image_data[30], image_data[23:0]});
          chk("ready_n_high_ge2", 32'(hi >= 2), 32'd1);
        end
        hi = image_data[31] ? hi + 1 : 0;
        prev_rn = image_data[31];
        prev_d  = image_data;
      end
    end
  endtask

  task automatic ack_loop();
    forever begin
      @(negedge clk);
      if (auto_ack && reset_n && !image_data[31]) begin
        repeat (3) @(negedge clk);
        ack_toggle = ~ack_toggle;
        repeat (2) @(negedge clk);
      end
    end
  endtask

  initial begin
    fork
      monitor_loop();
      ack_loop();
      begin
        #3ms;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
      end
    join_none

    // 1: reset values, async reset mid-operation, disabled capture is inert
    repeat (3) @(negedge clk);
    chk("reset_image_data", image_data, 32'h8000_0000);
    chk("reset_fifo_level", 32'(fifo_level), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_image_data", image_data, 32'h8000_0000);
    capture_en = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(32'h4001_0203);
    frame_start();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    wait_drain("t1_first");
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
    repeat (4) @(negedge clk);
    chk("t1_level_before_reset", 32'(fifo_level), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_async_image_data", image_data, 32'h8000_0000);
    chk("t1_async_fifo_level", 32'(fifo_level), 32'd0);
    capture_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    frame_start();
    send_byte(8'h07); send_byte(8'h08); send_byte(8'h09); send_byte(8'h0A);
    end_line();
    repeat (6) @(negedge clk);
    chk("t1_disabled_image_data", image_data, 32'h8000_0000);
    chk("t1_disabled_fifo_level", 32'(fifo_level), 32'd0);

    // 2: first frame, one six-byte line
    capture_en = 1'b1;
    auto_ack = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(32'h4011_2233);
    exp_q.push_back(32'h0044_5566);
    frame_start();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    end_line();
    wait_drain("t2");
    chk("t2_ready_n_after_ack", {31'b0, image_data[31]}, 32'd1);

    // 3: partial flush at line end, next line starts at the top slot
    exp_q.push_back(32'h00AA_BBCC);
    exp_q.push_back(32'h00DD_0000);
    exp_q.push_back(32'h0001_0203);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    end_line();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    end_line();
    wait_drain("t3");

    // 5: ack coincident with a push into an empty FIFO, then an absorbed ack
    auto_ack = 1'b0;
    exp_q.push_back(32'h0012_3456);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    end_line();
    wait_drain("t5_setup");
    exp_q.push_back(32'h009A_BCDE);
    send_byte(8'h9A); send_byte(8'hBC); send_byte_ack(8'hDE);
    end_line();
    wait_drain("t5");
    chk("t5_level_after", 32'(fifo_level), 32'd0);
    auto_ack = 1'b1;
    repeat (10) @(negedge clk);
    auto_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_slot_released", {31'b0, image_data[31]}, 32'd1);

    // 4: overflow with a 4-deep FIFO and no acks
    exp_q.push_back(32'h0010_1112);
    for (int k = 0; k < 24; k++) send_byte(8'(8'h10 + k));
    end_line();
    repeat (4) @(negedge clk);
    chk("t4_fifo_level_full", 32'(fifo_level), 32'd4);
    chk("t4_overflow_flag", {31'b0, image_data[29]}, 32'd1);
    exp_q.push_back(32'h2013_1415);
    exp_q.push_back(32'h2016_1718);
    exp_q.push_back(32'h2019_1A1B);
    exp_q.push_back(32'h201C_1D1E);
    auto_ack = 1'b1;
    wait_drain("t4");
    capture_en = 1'b0;
    repeat (3) @(negedge clk);
    capture_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_overflow_cleared", {29'b0, image_data[31:29]}, 32'd4);

    // 6: disable mid-line with 2 bytes packed and 3 words buffered
    auto_ack = 1'b0;
    exp_q.push_back(32'h4021_2223);
    frame_start();
    for (int k = 0; k < 14; k++) send_byte(8'(8'h21 + k));
    repeat (4) @(negedge clk);
    chk("t6_level_before_abort", 32'(fifo_level), 32'd3);
    wait_drain("t6_first");
    capture_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_abort_level", 32'(fifo_level), 32'd0);
    chk("t6_abort_ready_n", {31'b0, image_data[31]}, 32'd1);
    end_line();
    auto_ack = 1'b1;
    capture_en = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(32'h4077_8899);
    frame_start();
    send_byte(8'h77); send_byte(8'h88); send_byte(8'h99);
    end_line();
    wait_drain("t6_sof");
    chk("t6_final_level", 32'(fifo_level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
